// File: rtl/hellorld_pkg.sv
// rtl/hellorld_pkg.sv - shared types, message length and message ROM for the hellorld transmitter
//
// Contents:
//   tx_state_t  - serial frame states (IDLE/START/DATA/STOP/GAP)
//   seq_state_t - message sequencer states
//   MSG_LEN     - bytes in the message ROM
//   MSG_ROM     - "Hellorld!\r\n", element 0 sent first
//   msg_byte()  - ROM lookup returning 0x00 outside the message
package hellorld_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_GAP
  } seq_state_t;

  localparam int MSG_LEN = 11;
  localparam int IDX_W   = 4;

  // Packed so that MSG_ROM[0] is 'H': the last element of the concatenation is index 0.
  localparam logic [MSG_LEN-1:0][7:0] MSG_ROM = {
    8'h0A, 8'h0D, 8'h21, 8'h64, 8'h6C, 8'h72,
    8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48
  };

  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx == IDX_W'(i)) b = MSG_ROM[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 serial transmitter, LSB first, fixed bit period
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   data[7:0]  - byte to send, taken when valid && ready
//   valid      - byte offered
//   ready      - idle, or last cycle of the stop bit (allows back-to-back frames)
//   txd        - registered serial output, idle high
module uart_tx_8n1
  import hellorld_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  tx_state_t  state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;
  logic       bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign txd     = txd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = 8'd0;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;

    if (state_q != IDLE) baud_d = bit_end ? 8'd0 : baud_q + 8'd1;

    case (state_q)
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            // shift_q[0] is the bit on the line; the next one is shift_q[1].
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: ;
    endcase

    // A byte accepted on the final stop cycle starts its start bit on the next cycle.
    if (valid && ready) begin
      state_d = START;
      shift_d = data;
      baud_d  = 8'd0;
      bit_d   = 3'd0;
      txd_d   = 1'b0;
    end
  end

endmodule

// File: rtl/hellorld_msg_tx.sv
// rtl/hellorld_msg_tx.sv - repeating "Hellorld!\r\n" 8N1 message source for the UART TXD pin
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   en              - run enable, looked at only between messages
//   txd             - serial data, idle high
//   busy            - frame or inter-message gap in progress
//   char_strobe     - one-cycle pulse on the first start-bit cycle of each byte
//   msg_done        - one-cycle pulse as the stop bit of the last byte completes
//   msg_count[7:0]  - completed messages since reset, wraps
module hellorld_msg_tx
  import hellorld_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5,
  parameter int GAP_BITS     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       txd,
  output logic       busy,
  output logic       char_strobe,
  output logic       msg_done,
  output logic [7:0] msg_count
);

  localparam int               GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam logic [15:0]      GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(MSG_LEN - 1);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      gap_q, gap_d;
  logic [7:0]       count_q, count_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             tx_valid, tx_ready;
  logic [7:0]       tx_data;

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .txd  (txd)
  );

  assign busy        = busy_q;
  assign char_strobe = strobe_q;
  assign msg_done    = done_q;
  assign msg_count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEQ_IDLE;
      idx_q    <= '0;
      gap_q    <= 16'd0;
      count_q  <= 8'd0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    count_d  = count_q;
    done_d   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = msg_byte(idx_q);

    case (state_q)
      SEQ_IDLE: begin
        if (en) begin
          tx_valid = 1'b1;
          tx_data  = msg_byte('0);
          idx_d    = '0;
          state_d  = SEQ_SEND;
        end
      end
      SEQ_SEND: begin
        // While sending, ready only rises on the final stop cycle of the current byte.
        if (tx_ready) begin
          if (idx_q != IDX_LAST) begin
            tx_valid = 1'b1;
            tx_data  = msg_byte(idx_q + 4'd1);
            idx_d    = idx_q + 4'd1;
          end else begin
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
            idx_d   = '0;
            if (GAP_BITS > 0) begin
              state_d = SEQ_GAP;
              gap_d   = 16'd0;
            end else if (en) begin
              tx_valid = 1'b1;
              tx_data  = msg_byte('0);
            end else begin
              state_d = SEQ_IDLE;
            end
          end
        end
      end
      SEQ_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (en) begin
            tx_valid = 1'b1;
            tx_data  = msg_byte('0);
            state_d  = SEQ_SEND;
          end else begin
            state_d = SEQ_IDLE;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    strobe_d = tx_valid && tx_ready;
    busy_d   = (state_d != SEQ_IDLE);
  end

endmodule

// File: tb/tb_hellorld_msg_tx.sv
// tb/tb_hellorld_msg_tx.sv - scoreboard bench for hellorld_msg_tx
module tb_hellorld_msg_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_bc = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic txd_a, busy_a, char_strobe_a, msg_done_a;
  logic txd_b, busy_b, char_strobe_b, msg_done_b;
  logic txd_c, busy_c, char_strobe_c, msg_done_c;
  logic [7:0] msg_count_a, msg_count_b, msg_count_c;

  hellorld_msg_tx #(.CLKS_PER_BIT(5), .GAP_BITS(0)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .txd(txd_a), .busy(busy_a),
    .char_strobe(char_strobe_a), .msg_done(msg_done_a), .msg_count(msg_count_a));

  hellorld_msg_tx #(.CLKS_PER_BIT(5), .GAP_BITS(3)) dut_b (
    .clk(clk), .rst(rst_bc), .en(en_b), .txd(txd_b), .busy(busy_b),
    .char_strobe(char_strobe_b), .msg_done(msg_done_b), .msg_count(msg_count_b));

  hellorld_msg_tx #(.CLKS_PER_BIT(2), .GAP_BITS(0)) dut_c (
    .clk(clk), .rst(rst_bc), .en(en_c), .txd(txd_c), .busy(busy_c),
    .char_strobe(char_strobe_c), .msg_done(msg_done_c), .msg_count(msg_count_c));

  localparam int CPB = 5;
  logic [7:0] msg [11] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h72,
                           8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  logic [7:0] q_a[$];

  // Serial decoder: samples each bit CPB+1+CPB*k cycles after the falling edge.
  initial begin : mon_a
    logic prev;
    logic [8:0] bits;
    logic aborted;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!rst_a && prev && !txd_a) begin
        aborted = 1'b0;
        bits = '0;
        for (int c = 1; c <= 9 * CPB + 1 && !aborted; c++) begin
          @(posedge clk); #1;
          if (rst_a) aborted = 1'b1;
          else if (c >= CPB + 1 && (c - CPB - 1) % CPB == 0)
            bits[(c - CPB - 1) / CPB] = txd_a;
        end
        if (!aborted) begin
          check("frame_expected", int'(q_a.size() > 0), 1);
          if (q_a.size() > 0) check("rx_byte", int'(bits[7:0]), int'(q_a.pop_front()));
          check("stop_bit", int'(bits[8]), 1);
        end
      end
      prev = txd_a;
    end
  end

  int cyc = 0, done_a = 0, strobe_a = 0, in_msg_a = 0;
  int last_done_a = -1, last_strobe_a = 0;
  logic [7:0] exp_cnt_a = 8'd0;
  logic period_chk = 1'b0;

  initial begin : count_a
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst_a) begin
        exp_cnt_a = 8'd0;
        in_msg_a = 0;
        last_done_a = -1;
      end else begin
        if (msg_done_a) begin
          done_a++;
          exp_cnt_a = exp_cnt_a + 8'd1;
          check("msg_count_a", int'(msg_count_a), int'(exp_cnt_a));
          check("strobes_per_msg", in_msg_a, 11);
          if (period_chk && last_done_a >= 0) check("msg_period", cyc - last_done_a, 550);
          last_done_a = cyc;
          in_msg_a = 0;
        end
        if (char_strobe_a) begin
          strobe_a++;
          in_msg_a++;
          check("strobe_on_start_bit", int'(txd_a), 0);
          if (in_msg_a > 1) check("frame_len", cyc - last_strobe_a, 50);
          last_strobe_a = cyc;
        end
      end
    end
  end

  int done_c = 0;
  logic [7:0] exp_cnt_c = 8'd0;
  initial begin : count_c
    forever begin
      @(posedge clk); #1;
      if (!rst_bc && msg_done_c) begin
        done_c++;
        exp_cnt_c = exp_cnt_c + 8'd1;
        check("msg_count_c", int'(msg_count_c), int'(exp_cnt_c));
      end
    end
  end

  task automatic wait_done_a(input int target, input int limit);
    for (int i = 0; i < limit && done_a < target; i++) begin @(posedge clk); #2; end
    check("wait_done_a", done_a, target);
  endtask

  task automatic wait_strobe_a(input int target, input int limit);
    for (int i = 0; i < limit && strobe_a < target; i++) begin @(posedge clk); #2; end
    check("wait_strobe_a", strobe_a, target);
  endtask

  task automatic phase_a();
    repeat (4) @(posedge clk);
    #1;
    check("idle_txd_a", int'(txd_a), 1);
    check("idle_busy_a", int'(busy_a), 0);
    period_chk = 1'b1;
    for (int m = 0; m < 5; m++)
      for (int i = 0; i < 11; i++) q_a.push_back(msg[i]);
    en_a = 1'b1;
    @(posedge clk); #1;
    check("en_to_txd_latency", int'(txd_a), 0);
    check("busy_a_running", int'(busy_a), 1);
    wait_done_a(4, 3000);
    wait_strobe_a(49, 300);
    repeat (15) @(posedge clk);
    #1 en_a = 1'b0;
    wait_done_a(5, 1000);
    period_chk = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("after_drop_txd", int'(txd_a), 1);
    check("after_drop_busy", int'(busy_a), 0);
    check("after_drop_count", int'(msg_count_a), 5);
    repeat (100) @(posedge clk);
    #2;
    check("total_strobes", strobe_a, 55);

    // Reset in the middle of byte 2: only bytes 0 and 1 complete.
    q_a.push_back(msg[0]);
    q_a.push_back(msg[1]);
    en_a = 1'b1;
    wait_strobe_a(58, 200);
    repeat (20) @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    check("async_rst_txd", int'(txd_a), 1);
    check("async_rst_count", int'(msg_count_a), 0);
    check("async_rst_busy", int'(busy_a), 0);
    @(posedge clk);
    #2 rst_a = 1'b0;
    for (int i = 0; i < 11; i++) q_a.push_back(msg[i]);
    wait_strobe_a(60, 200);
    en_a = 1'b0;
    wait_done_a(6, 1500);
    repeat (60) @(posedge clk);
    #1;
    check("restart_count", int'(msg_count_a), 1);
    check("restart_busy", int'(busy_a), 0);
    check("queue_drained", q_a.size(), 0);
  endtask

  task automatic phase_b();
    int n, t, t0;
    t = 0;
    en_b = 1'b1;
    for (n = 0; n < 1500 && !msg_done_b; n++) begin @(posedge clk); #1; t++; end
    check("done_b_first", int'(msg_done_b), 1);
    check("busy_in_gap", int'(busy_b), 1);
    t0 = t;
    n = 0;
    while (txd_b && n < 100) begin n++; @(posedge clk); #1; t++; end
    check("gap_high_cycles", n, 15);
    check("gap_then_strobe", int'(char_strobe_b), 1);
    for (n = 0; n < 1500 && !msg_done_b; n++) begin @(posedge clk); #1; t++; end
    check("done_b_second", int'(msg_done_b), 1);
    check("period_with_gap", t - t0, 565);
    en_b = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("gap_to_idle_busy", int'(busy_b), 0);
    check("gap_to_idle_txd", int'(txd_b), 1);
    check("gap_count_b", int'(msg_count_b), 2);
  endtask

  task automatic phase_c();
    en_c = 1'b1;
    for (int i = 0; i < 60000 && done_c < 255; i++) begin @(posedge clk); #2; end
    check("wait_done_c_255", done_c, 255);
    en_c = 1'b0;
    for (int i = 0; i < 500 && done_c < 256; i++) begin @(posedge clk); #2; end
    repeat (20) @(posedge clk);
    #2;
    check("done_c_total", done_c, 256);
    check("count_c_wrapped", int'(msg_count_c), 0);
    check("busy_c_idle", int'(busy_c), 0);
    check("txd_c_idle", int'(txd_c), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", int'(txd_a), 1);
    check("rst_busy", int'(busy_a), 0);
    check("rst_char_strobe", int'(char_strobe_a), 0);
    check("rst_msg_done", int'(msg_done_a), 0);
    check("rst_msg_count", int'(msg_count_a), 0);
    check("rst_txd_b", int'(txd_b), 1);
    check("rst_count_c", int'(msg_count_c), 0);
    #1;
    rst_a = 1'b0;
    rst_bc = 1'b0;
    fork
      phase_a();
      phase_b();
      phase_c();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
